fifo_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the write port of one asynchronous FIFO among NUM_REQUESTERS producers in the write-clock domain.
- Grants one requester at a time for a bounded burst of up to MAX_BURST beats, then rotates priority.
- Drives the FIFO's write enable and write data, and back-pressures producers from the FIFO Full flag.

---
 rtl/fifo_write_arbiter.sv | 87 ++++++++
 tb/tb_fifo_write_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin arbiter sharing one async FIFO write port among
// several write-domain producers, with bounded bursts and Full back-pressure.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_REQUESTERS = 4,
    parameter int INDEX_WIDTH    = 2,
    parameter int MAX_BURST      = 4,
    parameter int BURST_WIDTH    = 4
) (
    input  logic                                 Write_Clock,
    input  logic                                 Write_Reset,
    input  logic [NUM_REQUESTERS-1:0]            Request_Valid,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] Request_Data,
    output logic [NUM_REQUESTERS-1:0]            Request_Ready,
    input  logic                                 Fifo_Full,
    output logic                                 Fifo_Write_Enable,
    output logic [DATA_WIDTH-1:0]                Fifo_Data_In,
    output logic                                 Grant_Valid,
    output logic [INDEX_WIDTH-1:0]               Grant_Index
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  r_state, w_state_next;
    logic [INDEX_WIDTH-1:0]  r_grant_index, r_last_grant, w_pick, w_idx;
    logic [BURST_WIDTH-1:0]  r_beat_count;
    logic [DATA_WIDTH-1:0]   w_grant_data;
    logic                    w_any_valid, w_sel_valid, w_transfer, w_release;

    // Search downwards so the nearest index after Last_Grant wins.
    always_comb begin
        w_pick = r_last_grant;
        w_idx  = '0;
        for (int k = NUM_REQUESTERS; k >= 1; k--) begin
            w_idx = INDEX_WIDTH'((int'(r_last_grant) + k) % NUM_REQUESTERS);
            if (Request_Valid[w_idx]) w_pick = w_idx;
        end
    end

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++)
            if (INDEX_WIDTH'(i) == r_grant_index) w_grant_data = Request_Data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_any_valid = |Request_Valid;
    assign w_sel_valid = Request_Valid[r_grant_index];
    assign w_transfer  = (r_state == GRANT) && w_sel_valid && !Fifo_Full;
    // A withdrawn valid ends the burst even while the FIFO is full.
    assign w_release   = (r_state == GRANT) &&
                         (!w_sel_valid || (w_transfer && r_beat_count == BURST_WIDTH'(MAX_BURST - 1)));

    always_ff @(posedge Write_Clock or posedge Write_Reset) begin
        if (Write_Reset) r_state <= IDLE;
        else             r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        Request_Ready = '0;
        Fifo_Data_In  = '0;
        if (r_state == IDLE) w_state_next = w_any_valid ? GRANT : IDLE;
        else                 w_state_next = w_release ? IDLE : GRANT;
        if (r_state == GRANT) begin
            Request_Ready[r_grant_index] = !Fifo_Full;
            Fifo_Data_In                 = w_grant_data;
        end
    end

    always_ff @(posedge Write_Clock or posedge Write_Reset) begin
        if (Write_Reset) begin
            r_grant_index <= '0;
            r_last_grant  <= INDEX_WIDTH'(NUM_REQUESTERS - 1);
            r_beat_count  <= '0;
        end else begin
            if (r_state == IDLE && w_any_valid) begin
                r_grant_index <= w_pick;
                r_beat_count  <= '0;
            end
            if (w_transfer) r_beat_count <= r_beat_count + BURST_WIDTH'(1);
            if (w_release) r_last_grant <= r_grant_index;
        end
    end

    assign Fifo_Write_Enable = w_transfer;
    assign Grant_Valid       = (r_state == GRANT);
    assign Grant_Index       = r_grant_index;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed and random checks of fifo_write_arbiter against
// a behavioural model and per-requester scoreboard queues.
module tb_fifo_write_arbiter;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    valid;
    logic [N*DW-1:0] data;
    logic [N-1:0]    ready;
    logic            full;
    logic            we;
    logic [DW-1:0]   din;
    logic            gv;
    logic [1:0]      gi;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQUESTERS(N), .INDEX_WIDTH(2), .MAX_BURST(MB), .BURST_WIDTH(4)
    ) dut (
        .Write_Clock(clk), .Write_Reset(rst), .Request_Valid(valid), .Request_Data(data),
        .Request_Ready(ready), .Fifo_Full(full), .Fifo_Write_Enable(we), .Fifo_Data_In(din),
        .Grant_Valid(gv), .Grant_Index(gi)
    );

    int checks = 0, errors = 0, cyc = 0, writes = 0, hs = 0, ready2_seen = 0;
    logic [N-1:0] want, pend;
    logic [7:0]   nxt[N];
    logic [7:0]   sbq[N][$];
    int           wlog_c[$];
    logic [7:0]   wlog_d[$];
    int           glog[$];
    logic         gv_prev;
    logic         m_g;
    logic [1:0]   m_idx, m_last;
    int           m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        logic [N-1:0] e_rdy;
        logic         e_we;
        logic [7:0]   e_din;
        logic         found;
        for (int i = 0; i < N; i++) begin
            if (want[i] && !pend[i]) begin
                pend[i] = 1'b1;
                sbq[i].push_back(nxt[i]);
            end
            valid[i] = pend[i];
            data[i*DW +: DW] = nxt[i];
        end
        if (rst) begin
            m_g = 1'b0; m_idx = 2'd0; m_last = 2'(N - 1); m_cnt = 0;
        end
        #4;
        e_rdy = '0;
        if (m_g) e_rdy[m_idx] = !full;
        e_we  = m_g && valid[m_idx] && !full;
        e_din = m_g ? nxt[m_idx] : 8'h00;
        chk("ready", 32'(ready), 32'(e_rdy));
        chk("write_enable", 32'(we), 32'(e_we));
        chk("fifo_data", 32'(din), 32'(e_din));
        chk("grant_valid", 32'(gv), 32'(m_g));
        chk("grant_index", 32'(gi), 32'(m_idx));
        if (ready[2]) ready2_seen++;
        if (gv && !gv_prev) glog.push_back(int'(gi));
        gv_prev = gv;
        if (we) begin
            writes++;
            chk("write_while_full", 32'(full), 32'd0);
            if (sbq[m_idx].size() == 0) chk("scoreboard_underflow", 32'd1, 32'd0);
            else chk("scoreboard_data", 32'(din), 32'(sbq[m_idx].pop_front()));
            wlog_c.push_back(cyc);
            wlog_d.push_back(din);
        end
        for (int i = 0; i < N; i++)
            if (valid[i] && ready[i]) begin
                hs++;
                pend[i] = 1'b0;
                nxt[i]  = nxt[i] + 8'd1;
            end
        if (!rst) begin
            if (!m_g) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (int'(m_last) + k) % N;
                    if (valid[j] && !found) begin
                        m_idx = 2'(j);
                        found = 1'b1;
                    end
                end
                if (found) begin
                    m_g = 1'b1; m_cnt = 0;
                end
            end else begin
                if (e_we) m_cnt++;
                if (!valid[m_idx] || (e_we && m_cnt == MB)) begin
                    m_g = 1'b0; m_last = m_idx;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; want = '0; pend = '0; full = 1'b0;
        for (int i = 0; i < N; i++) begin
            sbq[i].delete();
            nxt[i] = 8'(i * 64);
        end
        step();
        step();
        rst = 1'b0;
        wlog_c.delete(); wlog_d.delete(); glog.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        valid = '0; data = '0; full = 1'b0; want = '0; pend = '0; gv_prev = 1'b0;
        m_g = 1'b0; m_idx = 2'd0; m_last = 2'(N - 1); m_cnt = 0;
        @(posedge clk);
        #1;

        // Reset mid-burst, then requester 0 must win the first arbitration.
        do_reset();
        want[1] = 1'b1;
        repeat (3) step();
        chk("pre_reset_grant", 32'(glog.size() > 0 ? glog[0] : 99), 32'd1);
        chk("pre_reset_writes", 32'(wlog_d.size()), 32'd2);
        rst = 1'b1;
        want[0] = 1'b1;
        step();
        chk("reset_grant_valid", 32'(gv), 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_write_enable", 32'(we), 32'd0);
        chk("reset_grant_index", 32'(gi), 32'd0);
        rst = 1'b0;
        glog.delete();
        repeat (2) step();
        chk("post_reset_first_grant", 32'(glog.size() > 0 ? glog[0] : 99), 32'd0);

        // Lone streamer: 4 beats, one bubble, 4 beats.
        do_reset();
        nxt[2] = 8'h10;
        want[2] = 1'b1;
        repeat (10) step();
        chk("stream_writes", 32'(wlog_d.size()), 32'd8);
        if (wlog_d.size() >= 8) begin
            for (int k = 0; k < 8; k++) chk("stream_data", 32'(wlog_d[k]), 32'(8'h10 + k));
            chk("stream_burst1_span", 32'(wlog_c[3] - wlog_c[0]), 32'd3);
            chk("stream_bubble", 32'(wlog_c[4] - wlog_c[3]), 32'd2);
            chk("stream_burst2_span", 32'(wlog_c[7] - wlog_c[4]), 32'd3);
        end

        // Round-robin among 0, 1, 3.
        do_reset();
        ready2_seen = 0;
        want = 4'b1011;
        repeat (30) step();
        chk("rr_grants", 32'(glog.size()), 32'd6);
        if (glog.size() >= 6) begin
            chk("rr_order0", 32'(glog[0]), 32'd0);
            chk("rr_order1", 32'(glog[1]), 32'd1);
            chk("rr_order2", 32'(glog[2]), 32'd3);
            chk("rr_order3", 32'(glog[3]), 32'd0);
            chk("rr_order4", 32'(glog[4]), 32'd1);
            chk("rr_order5", 32'(glog[5]), 32'd3);
        end
        chk("rr_writes", 32'(wlog_d.size()), 32'd24);
        chk("rr_ready2_never", 32'(ready2_seen), 32'd0);

        // Full stall after beat 2 of requester 0.
        do_reset();
        want[0] = 1'b1;
        repeat (3) step();
        chk("stall_pre_writes", 32'(wlog_d.size()), 32'd2);
        full = 1'b1;
        repeat (5) step();
        chk("stall_writes", 32'(wlog_d.size()), 32'd2);
        chk("stall_grant_held", 32'(gv), 32'd1);
        full = 1'b0;
        repeat (2) step();
        want[0] = 1'b0;
        chk("stall_total_writes", 32'(wlog_d.size()), 32'd4);
        chk("stall_released", 32'(gv), 32'd0);
        if (wlog_d.size() >= 4) chk("stall_last_data", 32'(wlog_d[3]), 32'd3);
        step();

        // Early release by requester 3, then requester 0 wins over 1.
        wlog_c.delete(); wlog_d.delete();
        want[3] = 1'b1;
        repeat (3) step();
        chk("early_writes", 32'(wlog_d.size()), 32'd2);
        if (wlog_d.size() >= 2) chk("early_data", 32'(wlog_d[1]), 32'hC1);
        want[3] = 1'b0;
        want[0] = 1'b1;
        want[1] = 1'b1;
        step();
        chk("early_released", 32'(gv), 32'd0);
        step();
        chk("early_next_grant_valid", 32'(gv), 32'd1);
        chk("early_next_grant_index", 32'(gi), 32'd0);

        // Random traffic and Full.
        do_reset();
        hs = 0;
        writes = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) want[i] = ($urandom_range(0, 3) != 0);
            full = ($urandom_range(0, 3) == 0);
            step();
        end
        chk("random_writes_eq_handshakes", 32'(writes), 32'(hs));
        for (int i = 0; i < N; i++) chk("random_leftover", 32'(sbq[i].size()), 32'(pend[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
